// File: rtl/nukv_value_drop_filter.sv
// nukv_value_drop_filter
// Buffers one value at a time (a run of beats ending in value_last) and
// forwards it only if no beat of that value carried value_drop. Values
// longer than the buffer are flagged and swallowed. Forwarded and discarded
// values are counted in free-running 32-bit statistics.
module nukv_value_drop_filter #(
  parameter int MEMORY_WIDTH = 512,
  parameter int BUF_BITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] value_data,
  input  logic                    value_valid,
  input  logic                    value_last,
  input  logic                    value_drop,
  output logic                    value_ready,
  output logic [MEMORY_WIDTH-1:0] output_data,
  output logic                    output_valid,
  output logic                    output_last,
  input  logic                    output_ready,
  output logic [31:0]             stat_kept,
  output logic [31:0]             stat_dropped,
  output logic                    error_oversize
);

  localparam int DEPTH = 1 << BUF_BITS;

  typedef enum logic [1:0] {FILL, DRAIN, SKIP} state_t;

  state_t                  state;
  logic [BUF_BITS-1:0]     wr_ptr;
  logic [BUF_BITS-1:0]     rd_ptr;
  logic [BUF_BITS:0]       beat_cnt;
  logic                    drop_acc;
  logic [MEMORY_WIDTH-1:0] buf_mem [DEPTH];

  logic                    in_xfer;
  logic                    out_xfer;
  logic                    drop_now;
  logic [BUF_BITS-1:0]     rd_next;
  logic [BUF_BITS:0]       last_idx;

  // Input is accepted while collecting or skipping, never while draining or in reset
  assign value_ready = rst && (state != DRAIN);
  assign in_xfer     = value_valid && value_ready;
  assign out_xfer    = output_valid && output_ready;
  assign drop_now    = drop_acc | value_drop;
  assign rd_next     = rd_ptr + 1'b1;
  assign last_idx    = beat_cnt - 1'b1;

  // Value storage; no reset because every slot is written before it is read
  always_ff @(posedge clk) begin
    if (state == FILL && in_xfer) begin
      buf_mem[wr_ptr] <= value_data;
    end
  end

  // Control FSM with registered output beat, pointers and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      beat_cnt       <= '0;
      drop_acc       <= 1'b0;
      output_valid   <= 1'b0;
      output_last    <= 1'b0;
      output_data    <= '0;
      stat_kept      <= '0;
      stat_dropped   <= '0;
      error_oversize <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            if (value_last) begin
              if (drop_now) begin
                wr_ptr       <= '0;
                drop_acc     <= 1'b0;
                stat_dropped <= stat_dropped + 32'd1;
              end else begin
                // The last beat lands in the buffer on this same edge, so a
                // single-beat value is presented straight from the input.
                state        <= DRAIN;
                beat_cnt     <= {1'b0, wr_ptr} + 1'b1;
                rd_ptr       <= '0;
                output_valid <= 1'b1;
                output_last  <= (wr_ptr == '0);
                output_data  <= (wr_ptr == '0) ? value_data : buf_mem[0];
              end
            end else if (&wr_ptr) begin
              error_oversize <= 1'b1;
              state          <= SKIP;
            end else begin
              wr_ptr   <= wr_ptr + 1'b1;
              drop_acc <= drop_now;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (output_last) begin
              state        <= FILL;
              output_valid <= 1'b0;
              output_last  <= 1'b0;
              stat_kept    <= stat_kept + 32'd1;
              wr_ptr       <= '0;
              rd_ptr       <= '0;
              drop_acc     <= 1'b0;
            end else begin
              rd_ptr      <= rd_next;
              output_data <= buf_mem[rd_next];
              output_last <= ({1'b0, rd_next} == last_idx);
            end
          end
        end
        SKIP: begin
          if (in_xfer && value_last) begin
            state        <= FILL;
            stat_dropped <= stat_dropped + 32'd1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            drop_acc     <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_nukv_value_drop_filter.sv
// Testbench for nukv_value_drop_filter: directed scenarios plus randomized
// values checked against a value-level reference model (queue of expected
// output beats and expected statistics).
module tb_nukv_value_drop_filter;

  localparam int MW = 512;

  logic          clk;
  logic          rst;
  logic [MW-1:0] value_data;
  logic          value_valid;
  logic          value_last;
  logic          value_drop;
  logic          value_ready;
  logic [MW-1:0] output_data;
  logic          output_valid;
  logic          output_last;
  logic          output_ready;
  logic [31:0]   stat_kept;
  logic [31:0]   stat_dropped;
  logic          error_oversize;

  int checkCount;
  int errCount;
  int outXfers;

  // Reference model state
  logic [MW-1:0] expData[$];
  bit            expLast[$];
  logic [31:0]   expKept;
  logic [31:0]   expDropped;
  logic          expErr;

  // Ready control: 0 = always ready, 1 = random, 2 = manual value
  int   readyMode;
  logic manualReady;

  nukv_value_drop_filter dut (
    .clk            (clk),
    .rst            (rst),
    .value_data     (value_data),
    .value_valid    (value_valid),
    .value_last     (value_last),
    .value_drop     (value_drop),
    .value_ready    (value_ready),
    .output_data    (output_data),
    .output_valid   (output_valid),
    .output_last    (output_last),
    .output_ready   (output_ready),
    .stat_kept      (stat_kept),
    .stat_dropped   (stat_dropped),
    .error_oversize (error_oversize)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if it does not match
  task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                             input logic [MW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [MW-1:0] randData();
    logic [MW-1:0] d;
    for (int k = 0; k < MW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Drives output_ready a little after each rising edge
  initial begin
    output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        1:       output_ready = ($urandom_range(0, 3) != 0);
        2:       output_ready = manualReady;
        default: output_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: ordering, hold-while-stalled and input stall during drain
  initial begin
    logic          prevStall;
    logic [MW-1:0] prevData;
    logic          prevLast;
    logic [MW-1:0] ed;
    bit            el;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("hold_valid", output_valid, 1);
          checkOutput("hold_data", output_data, prevData);
          checkOutput("hold_last", output_last, prevLast);
        end
        if (output_valid) checkOutput("input_stalled", value_ready, 0);
        if (output_valid && output_ready) begin
          outXfers++;
          if (expData.size() == 0) begin
            checkOutput("spurious_beat", output_valid, 0);
          end else begin
            ed = expData.pop_front();
            el = expLast.pop_front();
            checkOutput("out_data", output_data, ed);
            checkOutput("out_last", output_last, el);
          end
        end
        prevStall = output_valid && !output_ready;
        prevData  = output_data;
        prevLast  = output_last;
      end
    end
  end

  // Sends one value of len beats; dropIdx marks the beat carrying drop (-1 none);
  // base >= 0 gives data base+i, otherwise random data. Entered and left at posedge+1.
  task automatic applyStimulus(input int len, input int dropIdx, input int base);
    bit oversize;
    bit dropped;
    bit acc;
    int tries;
    logic [MW-1:0] d;
    oversize = (len > 16);
    dropped  = oversize || (dropIdx >= 0);
    for (int i = 0; i < len; i++) begin
      d = (base >= 0) ? MW'(base + i) : randData();
      if (!dropped) begin
        expData.push_back(d);
        expLast.push_back(i == len - 1);
      end
      value_valid = 1'b1;
      value_data  = d;
      value_last  = (i == len - 1);
      value_drop  = (i == dropIdx);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 200) begin
        @(negedge clk);
        acc = value_ready;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!acc) checkOutput("input_timeout", value_ready, 1);
      if (oversize && i == 15) checkOutput("oversize_flag", error_oversize, 1);
    end
    value_valid = 1'b0;
    value_last  = 1'b0;
    value_drop  = 1'b0;
    if (dropped) expDropped = expDropped + 32'd1;
    else         expKept    = expKept + 32'd1;
    if (oversize) expErr = 1'b1;
  endtask

  // Waits until every expected beat has drained, then returns at posedge+1
  task automatic waitIdle();
    int n;
    n = 0;
    while ((expData.size() != 0 || output_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) checkOutput("idle_timeout", output_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "_kept"}, stat_kept, expKept);
    checkOutput({tag, "_dropped"}, stat_dropped, expDropped);
    checkOutput({tag, "_oversize"}, error_oversize, expErr);
    checkOutput({tag, "_pending"}, expData.size(), 0);
  endtask

  initial begin
    int len;
    int dIdx;
    int x0;
    logic [3:0] pat;
    checkCount  = 0;
    errCount    = 0;
    outXfers    = 0;
    expKept     = '0;
    expDropped  = '0;
    expErr      = 1'b0;
    readyMode   = 0;
    manualReady = 1'b0;
    rst         = 1'b0;
    value_valid = 1'b0;
    value_last  = 1'b0;
    value_drop  = 1'b0;
    value_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", output_valid, 0);
    checkOutput("rst_last", output_last, 0);
    checkOutput("rst_ready", value_ready, 0);
    checkStats("rst");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", value_ready, 1);
    @(posedge clk);
    #1;

    // Scenario 1: 3-beat kept value, output starts the cycle after the last beat
    applyStimulus(3, -1, 'hA);
    for (int i = 0; i < 3; i++) begin
      checkOutput("s1_valid", output_valid, 1);
      checkOutput("s1_data", output_data, MW'('hA + i));
      @(posedge clk);
      #1;
    end
    checkOutput("s1_done", output_valid, 0);
    waitIdle();
    checkStats("s1");

    // Scenario 2: dropped 4-beat value, then 1-beat kept value
    applyStimulus(4, 1, 'h10);
    checkOutput("s2_no_output", output_valid, 0);
    waitIdle();
    applyStimulus(1, -1, 'h5);
    checkOutput("s2_single_valid", output_valid, 1);
    checkOutput("s2_single_last", output_last, 1);
    waitIdle();
    checkStats("s2");

    // Scenario 3: output_ready toggling 0,1,0,1 during drain
    readyMode   = 2;
    manualReady = 1'b0;
    applyStimulus(2, -1, 'h20);
    x0  = outXfers;
    pat = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      manualReady = pat[k];
      @(posedge clk);
      #1;
    end
    manualReady = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("s3_xfers", outXfers - x0, 2);
    checkOutput("s3_drained", output_valid, 0);
    readyMode = 0;
    waitIdle();
    checkStats("s3");

    // Scenario 4: 20-beat oversize value, then a normal 1-beat value
    applyStimulus(20, -1, 'h100);
    waitIdle();
    checkStats("s4a");
    applyStimulus(1, -1, 'h7);
    waitIdle();
    checkStats("s4b");

    // Scenario 5: reset after one of three beats has drained
    applyStimulus(3, -1, 'h30);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    expData.delete();
    expLast.delete();
    expKept    = '0;
    expDropped = '0;
    expErr     = 1'b0;
    checkOutput("s5_valid", output_valid, 0);
    checkOutput("s5_ready", value_ready, 0);
    checkStats("s5_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(2, -1, 'h40);
    waitIdle();
    checkStats("s5");

    // Randomized values, occasional drops and oversize, random backpressure
    readyMode = 1;
    for (int n = 0; n < 25; n++) begin
      len  = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 20) : $urandom_range(1, 16);
      dIdx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      applyStimulus(len, dIdx, -1);
    end
    waitIdle();
    checkStats("rand");

    // Scenario 6: kept counter wraps
    readyMode = 0;
    force dut.stat_kept = 32'hFFFF_FFFF;
    expKept = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.stat_kept;
    @(posedge clk);
    #1;
    checkOutput("s6_preload", stat_kept, 32'hFFFF_FFFF);
    applyStimulus(1, -1, 'h66);
    waitIdle();
    checkStats("s6");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
